pipeline_ctrl: RTL and testbench

//  Central stall/flush/halt sequencer for the 5-stage hart. Merges the decode load-use stall, the execute

---
 rtl/pipeline_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Stall/flush/halt sequencer for the 5-stage hart. Merges hazard,
//             redirect and memory-wait inputs into per-stage enables and
//             bubble/flush controls, and runs the RUN/DRAIN/HALTED/TRAP
//             machine that stops fetch and drains on halt or illegal opcode.
//  Options  : PIPELINE_CTRL_PERF_EN - when defined, stall/flush performance
//             counters are built; otherwise both counter outputs are 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
   parameter int DRAIN_MAX = 16,
   parameter int CNT_W     = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ld_use_stall,
   input  logic             i_flush,
   input  logic             i_dec_valid,
   input  logic             i_dec_halt,
   input  logic             i_dec_trap,
   input  logic             i_imem_ready,
   input  logic             i_dmem_busy,
   input  logic             i_wb_halt,
   output logic             o_pc_en,
   output logic             o_if_id_en,
   output logic             o_if_id_flush,
   output logic             o_id_ex_en,
   output logic             o_id_ex_bubble,
   output logic             o_ex_mem_en,
   output logic             o_mem_wb_en,
   output logic [1:0]       o_state,
   output logic             o_halted,
   output logic             o_trap,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   localparam logic [1:0] ST_RUN    = 2'b00;
   localparam logic [1:0] ST_DRAIN  = 2'b01;
   localparam logic [1:0] ST_HALTED = 2'b10;
   localparam logic [1:0] ST_TRAP   = 2'b11;

   localparam int         DW        = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 1;
   localparam logic [DW-1:0] C_DRAIN_LAST = DW'(DRAIN_MAX - 1);

   logic [1:0]    state_q,  state_d;
   logic          cause_q,  cause_d;
   logic [DW-1:0] drain_q,  drain_d;
   logic          halted_q;
   logic          trap_q;

   logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_en, w_id_ex_bubble;
   logic w_ex_mem_en, w_mem_wb_en;

   // Stage controls and next-state selection from current state and hazards
   always_comb begin
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_en     = 1'b0;
      w_id_ex_bubble = 1'b0;
      w_ex_mem_en    = 1'b0;
      w_mem_wb_en    = 1'b0;
      state_d        = state_q;
      cause_d        = cause_q;
      drain_d        = drain_q;

      case (state_q)
         ST_RUN: begin
            if (i_dmem_busy) begin
               // Full freeze; a pending redirect stays asserted by EX
            end else if (i_flush) begin
               w_pc_en        = 1'b1;
               w_if_id_en     = 1'b1;
               w_if_id_flush  = 1'b1;
               w_id_ex_en     = 1'b1;
               w_id_ex_bubble = 1'b1;
               w_ex_mem_en    = 1'b1;
               w_mem_wb_en    = 1'b1;
            end else if (i_ld_use_stall) begin
               w_id_ex_en     = 1'b1;
               w_id_ex_bubble = 1'b1;
               w_ex_mem_en    = 1'b1;
               w_mem_wb_en    = 1'b1;
            end else if (!i_imem_ready) begin
               w_if_id_en     = 1'b1;
               w_if_id_flush  = 1'b1;
               w_id_ex_en     = 1'b1;
               w_ex_mem_en    = 1'b1;
               w_mem_wb_en    = 1'b1;
            end else begin
               w_pc_en        = 1'b1;
               w_if_id_en     = 1'b1;
               w_id_ex_en     = 1'b1;
               w_ex_mem_en    = 1'b1;
               w_mem_wb_en    = 1'b1;
            end
            // Halt/trap moves into ID/EX this cycle; stop fetch behind it
            if (i_dec_valid && (i_dec_halt || i_dec_trap) && !i_flush && !i_dmem_busy) begin
               state_d = ST_DRAIN;
               cause_d = i_dec_trap;
               drain_d = '0;
            end
         end
         ST_DRAIN: begin
            if (!i_dmem_busy) begin
               if (i_flush) begin
                  // Halt was on the wrong path: redirect and resume fetching
                  w_pc_en        = 1'b1;
                  w_if_id_en     = 1'b1;
                  w_if_id_flush  = 1'b1;
                  w_id_ex_en     = 1'b1;
                  w_id_ex_bubble = 1'b1;
                  w_ex_mem_en    = 1'b1;
                  w_mem_wb_en    = 1'b1;
                  state_d        = ST_RUN;
                  cause_d        = 1'b0;
                  drain_d        = '0;
               end else begin
                  w_id_ex_en     = 1'b1;
                  w_id_ex_bubble = 1'b1;
                  w_ex_mem_en    = 1'b1;
                  w_mem_wb_en    = 1'b1;
                  drain_d        = drain_q + DW'(1);
                  if (i_wb_halt) begin
                     state_d = cause_q ? ST_TRAP : ST_HALTED;
                  end else if (drain_q == C_DRAIN_LAST) begin
                     state_d = ST_TRAP;
                  end
               end
            end
         end
         default: begin
            // HALTED and TRAP hold everything until reset
         end
      endcase
   end

   // Controls are forced idle while reset is held
   assign o_pc_en        = w_pc_en        & i_rst;
   assign o_if_id_en     = w_if_id_en     & i_rst;
   assign o_if_id_flush  = w_if_id_flush  & i_rst;
   assign o_id_ex_en     = w_id_ex_en     & i_rst;
   assign o_id_ex_bubble = w_id_ex_bubble & i_rst;
   assign o_ex_mem_en    = w_ex_mem_en    & i_rst;
   assign o_mem_wb_en    = w_mem_wb_en    & i_rst;
   assign o_state        = state_q;
   assign o_halted       = halted_q;
   assign o_trap         = trap_q;

   // Sequencer state, drain timer and registered status flags
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= ST_RUN;
         cause_q  <= 1'b0;
         drain_q  <= '0;
         halted_q <= 1'b0;
         trap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         drain_q  <= drain_d;
         halted_q <= (state_d == ST_HALTED) || (state_d == ST_TRAP);
         trap_q   <= (state_d == ST_TRAP);
      end
   end

`ifdef PIPELINE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Count fetch-stalled RUN cycles and accepted redirects; both wrap
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if ((state_q == ST_RUN) && !w_pc_en)
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (i_flush && !i_dmem_busy)
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_ctrl
//  Purpose  : Directed self-checking bench for pipeline_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_use, flush, dec_valid, dec_halt, dec_trap;
   logic        imem_ready, dmem_busy, wb_halt;
   logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en;
   logic [1:0]  state;
   logic        halted, trap;
   logic [31:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;

   // ctrl = {pc, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem, mem_wb}
   localparam logic [6:0] C_RUN   = 7'b1101011;
   localparam logic [6:0] C_LDUSE = 7'b0001111;
   localparam logic [6:0] C_FLUSH = 7'b1111111;
   localparam logic [6:0] C_IMEM  = 7'b0111011;
   localparam logic [6:0] C_DRAIN = 7'b0001111;
   localparam logic [6:0] C_OFF   = 7'b0000000;

   wire [6:0] ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en};

   pipeline_ctrl #(.DRAIN_MAX(16), .CNT_W(32)) dut (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .i_ld_use_stall (ld_use),
      .i_flush        (flush),
      .i_dec_valid    (dec_valid),
      .i_dec_halt     (dec_halt),
      .i_dec_trap     (dec_trap),
      .i_imem_ready   (imem_ready),
      .i_dmem_busy    (dmem_busy),
      .i_wb_halt      (wb_halt),
      .o_pc_en        (pc_en),
      .o_if_id_en     (if_id_en),
      .o_if_id_flush  (if_id_flush),
      .o_id_ex_en     (id_ex_en),
      .o_id_ex_bubble (id_ex_bubble),
      .o_ex_mem_en    (ex_mem_en),
      .o_mem_wb_en    (mem_wb_en),
      .o_state        (state),
      .o_halted       (halted),
      .o_trap         (trap),
      .o_stall_cnt    (stall_cnt),
      .o_flush_cnt    (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are changed 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      ld_use = 0; flush = 0; dec_valid = 0; dec_halt = 0; dec_trap = 0;
      dmem_busy = 0; wb_halt = 0; imem_ready = 1;
   endtask

   initial begin
      clr();
      rst_n = 1'b0;
      tick(); tick();
      #1;
      chk("rst_ctrl",   32'(ctrl),   32'(C_OFF));
      chk("rst_state",  32'(state),  32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_trap",   32'(trap),   32'd0);
      chk("rst_stall",  stall_cnt,   32'd0);

      // Idle run
      rst_n = 1'b1;
      #1;
      chk("idle_ctrl",  32'(ctrl),  32'(C_RUN));
      tick();
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_halt",  32'(halted), 32'd0);

      // Load-use stall
      ld_use = 1; #1;
      chk("lduse_ctrl", 32'(ctrl), 32'(C_LDUSE));
      tick(); clr(); #1;
`ifdef PIPELINE_CTRL_PERF_EN
      chk("lduse_cnt", stall_cnt, 32'd1);
`else
      chk("lduse_cnt", stall_cnt, 32'd0);
`endif

      // Flush beats load-use
      ld_use = 1; flush = 1; #1;
      chk("flush_ctrl", 32'(ctrl), 32'(C_FLUSH));
      tick(); clr(); #1;
`ifdef PIPELINE_CTRL_PERF_EN
      chk("flush_cnt", flush_cnt, 32'd1);
      chk("flush_stl", stall_cnt, 32'd1);
`else
      chk("flush_cnt", flush_cnt, 32'd0);
`endif

      // Fetch not ready
      imem_ready = 0; #1;
      chk("imem_ctrl", 32'(ctrl), 32'(C_IMEM));
      tick(); clr();

      // Data memory busy freezes even with a pending flush
      dmem_busy = 1; flush = 1; #1;
      chk("busy_ctrl", 32'(ctrl), 32'(C_OFF));
      tick(); clr(); #1;
`ifdef PIPELINE_CTRL_PERF_EN
      chk("busy_stl", stall_cnt, 32'd3);
      chk("busy_fl",  flush_cnt, 32'd1);
`endif

      // Halt decode, drain three cycles, retire
      dec_valid = 1; dec_halt = 1; #1;
      chk("halt_dec_ctrl", 32'(ctrl), 32'(C_RUN));
      tick(); clr(); #1;
      chk("drain1_state", 32'(state), 32'd1);
      chk("drain1_ctrl",  32'(ctrl),  32'(C_DRAIN));
      tick();
      chk("drain2_state", 32'(state), 32'd1);
      tick();
      chk("drain3_state", 32'(state), 32'd1);
      wb_halt = 1;
      tick(); clr(); #1;
      chk("halted_state", 32'(state),  32'd2);
      chk("halted_flag",  32'(halted), 32'd1);
      chk("halted_trap",  32'(trap),   32'd0);
      chk("halted_ctrl",  32'(ctrl),   32'(C_OFF));

      // Asynchronous reset out of HALTED
      rst_n = 1'b0; #1;
      chk("arst_state",  32'(state),  32'd0);
      chk("arst_halted", 32'(halted), 32'd0);
      tick(); rst_n = 1'b1; #1;
      chk("arst_stall", stall_cnt, 32'd0);

      // Wrong-path halt cancelled by flush
      dec_valid = 1; dec_halt = 1;
      tick(); clr();
      chk("wp_drain", 32'(state), 32'd1);
      flush = 1; #1;
      chk("wp_ctrl", 32'(ctrl), 32'(C_FLUSH));
      tick(); clr(); #1;
      chk("wp_state", 32'(state), 32'd0);
      chk("wp_pc",    32'(pc_en), 32'd1);

      // Flush together with halt decode: no drain
      dec_valid = 1; dec_halt = 1; flush = 1;
      tick(); clr();
      chk("fh_state", 32'(state), 32'd0);

      // Illegal instruction, drain timeout to TRAP
      dec_valid = 1; dec_trap = 1;
      tick(); clr();
      for (int i = 0; i < 15; i++) tick();
      chk("to_last_drain", 32'(state), 32'd1);
      tick();
      chk("to_state",  32'(state),  32'd3);
      chk("to_trap",   32'(trap),   32'd1);
      chk("to_halted", 32'(halted), 32'd1);

      // Second run: reset in the middle of a trap drain
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      dec_valid = 1; dec_trap = 1;
      tick(); clr();
      for (int i = 0; i < 5; i++) tick();
      chk("mid_drain", 32'(state), 32'd1);
      rst_n = 1'b0; #1;
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_trap",  32'(trap),  32'd0);
      tick(); rst_n = 1'b1;

      // No residual cause: a plain halt must end in HALTED
      dec_valid = 1; dec_halt = 1;
      tick(); clr();
      wb_halt = 1;
      tick(); clr();
      chk("cause_state", 32'(state), 32'd2);
      chk("cause_trap",  32'(trap),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
